// File: rtl/data_mux_arbiter_pkg.sv
// Shared encodings and round-robin helper for the three-requester operand-bus arbiter.
package data_mux_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_1    = 2'b01;
    localparam logic [1:0] SEL_2    = 2'b10;
    localparam logic [1:0] SEL_3    = 2'b11;

    // First set request strictly after 'last' in the order 1->2->3->1; SEL_NONE if none.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] cand;
        pick = SEL_NONE;
        cand = last;
        for (int k = 0; k < 3; k++) begin
            cand = (cand == SEL_3) ? SEL_1 : cand + 2'd1;
            if (pick == SEL_NONE && r[cand - 2'd1])
                pick = cand;
        end
        return pick;
    endfunction

    function automatic logic [2:0] sel_to_gnt(input logic [1:0] s);
        logic [2:0] g;
        case (s)
            SEL_1:   g = 3'b001;
            SEL_2:   g = 3'b010;
            SEL_3:   g = 3'b100;
            default: g = 3'b000;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/data_mux3_1.sv
// 3:1 data mux; select SEL_NONE parks the bus at zero.
module data_mux3_1
    import data_mux_arbiter_pkg::*;
#(
    parameter int data_wl = 16
) (
    input  logic [1:0]         sel,
    input  logic [data_wl-1:0] in_1,
    input  logic [data_wl-1:0] in_2,
    input  logic [data_wl-1:0] in_3,
    output logic [data_wl-1:0] out
);

    always_comb begin
        case (sel)
            SEL_1:   out = in_1;
            SEL_2:   out = in_2;
            SEL_3:   out = in_3;
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/data_mux_arbiter.sv
// Round-robin arbiter with bounded hold time driving a shared 3:1 operand bus.
// Optional ARB_LOCK_EN macro adds a 'lock' input that lets the owner suppress preemption.
module data_mux_arbiter
    import data_mux_arbiter_pkg::*;
#(
    parameter int data_wl  = 16,
    parameter int MAX_HOLD = 8,
    parameter int HOLD_WL  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         req,
`ifdef ARB_LOCK_EN
    input  logic               lock,
`endif
    input  logic [data_wl-1:0] in_1,
    input  logic [data_wl-1:0] in_2,
    input  logic [data_wl-1:0] in_3,
    output logic [2:0]         gnt,
    output logic [1:0]         sel,
    output logic               busy,
    output logic [data_wl-1:0] out
);

    // Counter stops at MAX_HOLD so a late competitor still meets the preempt compare.
    localparam logic [HOLD_WL-1:0] CNT_CAP = (MAX_HOLD != 0) ? HOLD_WL'(MAX_HOLD) : '1;

    state_t             state;
    logic [HOLD_WL-1:0] cnt;
    logic [1:0]         last;

    logic       owner_req;
    logic       others;
    logic       lock_hold;
    logic       preempt;
    logic [1:0] idle_pick;
    logic [1:0] hand_pick;

    always_comb begin
        owner_req = |(req & gnt);
        others    = |(req & ~gnt);
`ifdef ARB_LOCK_EN
        lock_hold = lock & owner_req;
`else
        lock_hold = 1'b0;
`endif
        preempt   = owner_req && (MAX_HOLD != 0) && (cnt == CNT_CAP) && others && !lock_hold;
        idle_pick = rr_pick(req, last);
        hand_pick = rr_pick(req & ~gnt, sel);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            gnt   <= 3'b000;
            sel   <= SEL_NONE;
            busy  <= 1'b0;
            cnt   <= '0;
            last  <= SEL_3;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (idle_pick != SEL_NONE) begin
                        state <= ST_GRANT;
                        sel   <= idle_pick;
                        gnt   <= sel_to_gnt(idle_pick);
                        busy  <= 1'b1;
                        cnt   <= HOLD_WL'(1);
                    end
                end
                ST_GRANT: begin
                    if (owner_req && !preempt) begin
                        if (cnt != CNT_CAP)
                            cnt <= cnt + 1'b1;
                    end else begin
                        // Release or preempt: hand straight to the next requester, no idle bubble.
                        last <= sel;
                        if (hand_pick != SEL_NONE) begin
                            sel <= hand_pick;
                            gnt <= sel_to_gnt(hand_pick);
                            cnt <= HOLD_WL'(1);
                        end else begin
                            state <= ST_IDLE;
                            sel   <= SEL_NONE;
                            gnt   <= 3'b000;
                            busy  <= 1'b0;
                            cnt   <= '0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    data_mux3_1 #(.data_wl(data_wl)) u_mux (
        .sel  (sel),
        .in_1 (in_1),
        .in_2 (in_2),
        .in_3 (in_3),
        .out  (out)
    );

endmodule

// File: tb/tb_data_mux_arbiter.sv
// Scoreboard bench: each stimulus cycle queues the hand-computed post-edge outputs; a monitor pops and compares.
module tb_data_mux_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [15:0] in_1 = 16'hA5A5;
    logic [15:0] in_2 = 16'h5A5A;
    logic [15:0] in_3 = 16'h3C3C;
    logic [2:0]  gnt;
    logic [1:0]  sel;
    logic        busy;
    logic [15:0] out;
`ifdef ARB_LOCK_EN
    logic        lock = 1'b0;
`endif

    data_mux_arbiter #(.data_wl(16), .MAX_HOLD(8), .HOLD_WL(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
`ifdef ARB_LOCK_EN
        .lock  (lock),
`endif
        .in_1  (in_1),
        .in_2  (in_2),
        .in_3  (in_3),
        .gnt   (gnt),
        .sel   (sel),
        .busy  (busy),
        .out   (out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  g;
        logic [1:0]  s;
        logic        b;
        logic [15:0] o;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    function automatic exp_t mk(input logic [2:0] g);
        exp_t e;
        case (g)
            3'b001:  e = '{g: g, s: 2'b01, b: 1'b1, o: 16'hA5A5};
            3'b010:  e = '{g: g, s: 2'b10, b: 1'b1, o: 16'h5A5A};
            3'b100:  e = '{g: g, s: 2'b11, b: 1'b1, o: 16'h3C3C};
            default: e = '{g: 3'b000, s: 2'b00, b: 1'b0, o: 16'h0000};
        endcase
        return e;
    endfunction

    // Drive one cycle and queue the outputs expected right after the next rising edge.
    task automatic step(input logic r, input logic [2:0] q, input logic [2:0] eg);
        reset = r;
        req   = q;
        sb.push_back(mk(eg));
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n, input logic [2:0] q, input logic [2:0] eg);
        for (int i = 0; i < n; i++) step(1'b0, q, eg);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #3;
        cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({gnt, sel, busy, out} !== e) begin
                failures++;
                $display("FAIL cyc%0d outputs: got gnt=%b sel=%b busy=%b out=%h, want gnt=%b sel=%b busy=%b out=%h",
                         cyc, gnt, sel, busy, out, e.g, e.s, e.b, e.o);
            end
        end
    end

    initial begin
        // Reset held with all requesting, then requester 1 wins first.
        step(1'b1, 3'b111, 3'b000);
        step(1'b1, 3'b111, 3'b000);
        step(1'b0, 3'b111, 3'b001);
        step(1'b0, 3'b000, 3'b000);
        // Lone requester 2 for three cycles, released one cycle after drop.
        steps(3, 3'b010, 3'b010);
        step(1'b0, 3'b000, 3'b000);
        // Direct handoffs: 1 -> 2 -> 3 with no idle bubble.
        step(1'b0, 3'b001, 3'b001);
        step(1'b0, 3'b110, 3'b010);
        step(1'b0, 3'b101, 3'b100);
        step(1'b0, 3'b000, 3'b000);
        // Two competitors: rotation every MAX_HOLD cycles.
        steps(8, 3'b011, 3'b001);
        steps(8, 3'b011, 3'b010);
        step(1'b0, 3'b011, 3'b001);
        step(1'b0, 3'b000, 3'b000);
        // No competitor, no preemption.
        steps(20, 3'b001, 3'b001);
        step(1'b0, 3'b000, 3'b000);
        // Reset mid-grant restores the pointer: req=101 must go to 1, not 3.
        step(1'b0, 3'b001, 3'b001);
        step(1'b0, 3'b000, 3'b000);
        step(1'b0, 3'b100, 3'b100);
        step(1'b1, 3'b101, 3'b000);
        step(1'b0, 3'b101, 3'b001);
        step(1'b0, 3'b000, 3'b000);
`ifdef ARB_LOCK_EN
        // Locked owner keeps the bus past MAX_HOLD; unlocking rotates at once.
        lock = 1'b1;
        step(1'b0, 3'b001, 3'b001);
        steps(12, 3'b011, 3'b001);
        lock = 1'b0;
        step(1'b0, 3'b011, 3'b010);
        step(1'b0, 3'b000, 3'b000);
`endif
        step(1'b0, 3'b000, 3'b000);
        repeat (2) @(posedge clk);
        #5;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
